// File: rtl/mem_access_pkg.sv
// Shared constants and helpers for the MEM stage: FSM encodings, funct3 codes
// and the store lane/strobe rules.
package mem_access_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_WAIT  = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;

  localparam int MAX_WAIT_DEFAULT = 255;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // size is funct3[1:0]: 00 byte, 01 half, anything wider is treated as a word
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return addr_lo[0];
      default: return addr_lo != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] store_strobe(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      2'b00:   return 4'b0001 << addr_lo;
      2'b01:   return 4'b0011 << addr_lo;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] data);
    case (size)
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module load_extend
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_BU:   data = {24'b0, byte_sel};
      F3_HU:   data = {16'b0, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM stage of mini_cpu: runs loads/stores on the req/ack data bus and feeds
// the MEM/WB register, stalling upstream while an access is outstanding.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  in_regWAddr,
  input  logic [31:0] in_result,
  input  logic [31:0] in_storeData,
  input  logic        in_memRead,
  input  logic        in_memWrite,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_pc,
  input  logic        in_valid,
  input  logic        flush,
  output logic        stall,
  output logic [4:0]  out_regWAddr,
  output logic [31:0] out_result,
  output logic [31:0] out_readData,
  output logic [31:0] out_pc,
  output logic        out_valid,
  output logic        out_misalign,
  output logic        out_busErr,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [4:0]  cap_regWAddr;
  logic [31:0] cap_result;
  logic [31:0] cap_pc;
  logic [2:0]  cap_funct3;
  logic        cap_load;
  logic [31:0] ext_data;

  logic mem_op;
  logic addr_bad;
  logic accept;
  logic busy;
  logic wait_expired;
  logic done;

  assign mem_op   = in_valid & (in_memRead | in_memWrite);
  assign addr_bad = is_misaligned(in_funct3[1:0], in_result[1:0]);
  assign accept   = (state == ST_IDLE) & mem_op & ~addr_bad & ~flush;
  assign busy     = (state != ST_IDLE);
  // Expiry fires in the MAX_WAIT-th unacknowledged cycle; an ack in that same cycle wins.
  assign wait_expired = busy & ~dmem_ack & (wait_cnt == 8'(MAX_WAIT - 1));
  assign done     = busy & (dmem_ack | wait_expired);

  load_extend u_load_extend (
    .word    (dmem_rdata),
    .addr_lo (cap_result[1:0]),
    .funct3  (cap_funct3),
    .data    (ext_data)
  );

  always_comb begin
    stall        = 1'b0;
    out_regWAddr = in_regWAddr;
    out_result   = in_result;
    out_pc       = in_pc;
    out_readData = '0;
    out_valid    = 1'b0;
    out_misalign = 1'b0;
    out_busErr   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_op && !flush) begin
          if (addr_bad) begin
            out_valid    = 1'b1;
            out_regWAddr = '0;
            out_misalign = 1'b1;
          end else begin
            stall = 1'b1;
          end
        end else begin
          out_valid = in_valid & ~flush;
        end
      end
      ST_WAIT: begin
        out_regWAddr = cap_regWAddr;
        out_result   = cap_result;
        out_pc       = cap_pc;
        if (dmem_ack) begin
          out_valid    = ~flush;
          out_readData = cap_load ? ext_data : '0;
        end else if (wait_expired) begin
          out_valid    = ~flush;
          out_busErr   = ~flush;
          out_regWAddr = '0;
        end else begin
          stall = 1'b1;
        end
      end
      ST_DRAIN: begin
        out_regWAddr = cap_regWAddr;
        out_result   = cap_result;
        out_pc       = cap_pc;
        stall        = ~done;
      end
      default: ;
    endcase
  end

  // Bus fields are registered at acceptance and held untouched until the access completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      wait_cnt     <= '0;
      cap_regWAddr <= '0;
      cap_result   <= '0;
      cap_pc       <= '0;
      cap_funct3   <= '0;
      cap_load     <= 1'b0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      dmem_wstrb   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          wait_cnt <= '0;
          if (accept) begin
            cap_regWAddr <= in_regWAddr;
            cap_result   <= in_result;
            cap_pc       <= in_pc;
            cap_funct3   <= in_funct3;
            cap_load     <= in_memRead;
            dmem_req     <= 1'b1;
            dmem_we      <= ~in_memRead;
            dmem_addr    <= {in_result[31:2], 2'b00};
            dmem_wdata   <= in_memRead ? 32'h0 : store_data(in_funct3[1:0], in_storeData);
            dmem_wstrb   <= in_memRead ? 4'h0 : store_strobe(in_funct3[1:0], in_result[1:0]);
            state        <= ST_WAIT;
          end
        end
        ST_WAIT, ST_DRAIN: begin
          if (done) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_wstrb <= '0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (state == ST_WAIT && flush) state <= ST_DRAIN;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
